// File: rtl/mem_io_bridge_if.sv
// mem_io_bridge_if
// Groups the bus signals around mem_io_bridge into one bundle.
//   CPU side : cpu_a, cpu_wr, cpu_dout -> bridge ; cpu_din, cpu_rdy <- bridge
//   RAM side : ram_a, ram_we, ram_wdata <- bridge ; ram_rdata -> bridge
//   UART TX  : tx_data, tx_valid <- bridge ; tx_ready -> bridge
//   UART RX  : rx_data, rx_valid -> bridge ; rx_pop <- bridge
//   Status   : prog_stop <- bridge
//
// Handshakes: a TX byte transfers on any clock edge where tx_valid & tx_ready
// are both 1; tx_valid never depends combinationally on tx_ready. An RX byte is
// consumed on any edge where rx_pop is 1, and rx_pop is only raised while
// rx_valid is 1. A CPU access takes effect on any edge where cpu_rdy is 1; while
// cpu_rdy is 0 the CPU holds its address, strobe and data unchanged.
interface mem_io_bridge_if;
   logic [31:0] cpu_a;
   logic        cpu_wr;
   logic [7:0]  cpu_dout;
   logic [7:0]  cpu_din;
   logic        cpu_rdy;
   logic [16:0] ram_a;
   logic        ram_we;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_pop;
   logic        prog_stop;

   // Bridge side
   modport slave (
      input  cpu_a, cpu_wr, cpu_dout, ram_rdata, tx_ready, rx_data, rx_valid,
      output cpu_din, cpu_rdy, ram_a, ram_we, ram_wdata, tx_data, tx_valid,
             rx_pop, prog_stop
   );

   // System side (CPU, RAM, UART)
   modport master (
      output cpu_a, cpu_wr, cpu_dout, ram_rdata, tx_ready, rx_data, rx_valid,
      input  cpu_din, cpu_rdy, ram_a, ram_we, ram_wdata, tx_data, tx_valid,
             rx_pop, prog_stop
   );
endinterface

// File: rtl/mem_io_bridge.sv
// mem_io_bridge
// Decodes the CPU byte port into block RAM (0x00000-0x1FFFF), an unmapped
// hole (0x20000-0x2FFFF) and an I/O page (0x30000+, selected by cpu_a[2:0]).
// Buffers UART TX bytes in a FIFO, pops UART RX bytes, keeps a free-running
// cycle counter with a readable snapshot, and stalls the CPU through cpu_rdy.
// Ports:
//   clk_in, rst_in     : clock, asynchronous active-low reset
//   bus                : mem_io_bridge_if.slave (CPU, RAM, UART TX/RX, prog_stop)
//   dbg_tx_count_o     : TX FIFO occupancy
//   dbg_cycle_cnt_o    : free-running cycle counter
//   dbg_sel_o          : registered read-source selector
module mem_io_bridge #(
   parameter int TX_AW = 4
) (
   input  logic               clk_in,
   input  logic               rst_in,
   mem_io_bridge_if.slave     bus,
   output logic [TX_AW:0]     dbg_tx_count_o,
   output logic [31:0]        dbg_cycle_cnt_o,
   output logic [1:0]         dbg_sel_o
);

   typedef enum logic [1:0] {
      SEL_ZERO = 2'd0,
      SEL_RAM  = 2'd1,
      SEL_RX   = 2'd2,
      SEL_CNT  = 2'd3
   } sel_e;

   localparam logic [TX_AW:0] DEPTH = {1'b1, {TX_AW{1'b0}}};

   // Registers
   sel_e             sel_q, sel_d;
   logic [1:0]       byte_q, byte_d;
   logic [7:0]       rx_q, rx_d;
   logic [31:0]      cycle_cnt_q;
   logic [31:0]      snap_q, snap_d;
   logic             prog_stop_q, prog_stop_d;
   logic [TX_AW-1:0] wptr_q, rptr_q;
   logic [TX_AW:0]   count_q, count_d;
   logic [7:0]       mem_q [2**TX_AW];

   // Address decode
   logic       is_ram, is_io, io_rd, io_wr;
   logic [2:0] io_sel;
   logic       wr_tx, wr_stop, push_req, rd_rx;
   logic       fifo_full, tx_pop, accept, push;
   logic [7:0] push_data;
   logic       unused_addr_bits;

   assign unused_addr_bits = ^bus.cpu_a[31:18];

   assign is_ram = ~bus.cpu_a[17];
   assign is_io  = bus.cpu_a[17] & bus.cpu_a[16];
   assign io_sel = bus.cpu_a[2:0];
   assign io_rd  = is_io & ~bus.cpu_wr;
   assign io_wr  = is_io & bus.cpu_wr;

   // A null byte written to the data port is filtered out, so it never asks
   // for a FIFO slot and therefore can never stall.
   assign wr_tx    = io_wr & (io_sel == 3'd0) & (bus.cpu_dout != 8'h00);
   assign wr_stop  = io_wr & (io_sel == 3'd4);
   assign push_req = wr_tx | wr_stop;
   assign rd_rx    = io_rd & (io_sel == 3'd0);

   assign fifo_full = (count_q == DEPTH);
   assign bus.tx_valid = (count_q != '0);
   assign bus.tx_data  = mem_q[rptr_q];
   assign tx_pop       = bus.tx_valid & bus.tx_ready;

   // A pop in the same cycle frees the slot, so a full FIFO only stalls when
   // the UART is not draining it right now.
   assign bus.cpu_rdy = ~((push_req & fifo_full & ~tx_pop) |
                          (rd_rx & ~bus.rx_valid));
   assign accept = bus.cpu_rdy;

   assign push      = accept & push_req;
   assign push_data = wr_stop ? 8'h00 : bus.cpu_dout;

   assign bus.ram_a     = bus.cpu_a[16:0];
   assign bus.ram_wdata = bus.cpu_dout;
   assign bus.ram_we    = accept & bus.cpu_wr & is_ram;
   assign bus.rx_pop    = accept & rd_rx;
   assign bus.prog_stop = prog_stop_q;

   assign dbg_tx_count_o  = count_q;
   assign dbg_cycle_cnt_o = cycle_cnt_q;
   assign dbg_sel_o       = sel_q;

   // Next-state for accepted accesses
   always_comb begin
      sel_d       = sel_q;
      byte_d      = byte_q;
      rx_d        = rx_q;
      snap_d      = snap_q;
      prog_stop_d = prog_stop_q;
      if (accept) begin
         sel_d = SEL_ZERO;
         if (!bus.cpu_wr) begin
            if (is_ram) begin
               sel_d = SEL_RAM;
            end else if (rd_rx) begin
               sel_d = SEL_RX;
               rx_d  = bus.rx_data;
            end else if (is_io && io_sel[2]) begin
               // Only 0x30004 relatches; 0x30005..7 read the held snapshot.
               sel_d  = SEL_CNT;
               byte_d = io_sel[1:0];
               if (io_sel[1:0] == 2'd0) begin
                  snap_d = cycle_cnt_q;
               end
            end
         end
         if (wr_stop) begin
            prog_stop_d = 1'b1;
         end
      end
   end

   always_comb begin
      count_d = count_q;
      unique case ({push, tx_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         sel_q       <= SEL_ZERO;
         byte_q      <= 2'd0;
         rx_q        <= 8'h00;
         cycle_cnt_q <= 32'd0;
         snap_q      <= 32'd0;
         prog_stop_q <= 1'b0;
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
      end else begin
         sel_q       <= sel_d;
         byte_q      <= byte_d;
         rx_q        <= rx_d;
         cycle_cnt_q <= cycle_cnt_q + 32'd1;
         snap_q      <= snap_d;
         prog_stop_q <= prog_stop_d;
         count_q     <= count_d;
         if (push) begin
            wptr_q <= wptr_q + 1'b1;
         end
         if (tx_pop) begin
            rptr_q <= rptr_q + 1'b1;
         end
      end
   end

   // Storage needs no reset: an empty FIFO never exposes its contents.
   always_ff @(posedge clk_in) begin
      if (push) begin
         mem_q[wptr_q] <= push_data;
      end
   end

   // Read data path: RAM data arrives one cycle after the address, so the
   // selector registered at accept lines every source up with it.
   always_comb begin
      bus.cpu_din = 8'h00;
      unique case (sel_q)
         SEL_RAM:  bus.cpu_din = bus.ram_rdata;
         SEL_RX:   bus.cpu_din = rx_q;
         SEL_CNT: begin
            unique case (byte_q)
               2'd0:    bus.cpu_din = snap_q[7:0];
               2'd1:    bus.cpu_din = snap_q[15:8];
               2'd2:    bus.cpu_din = snap_q[23:16];
               default: bus.cpu_din = snap_q[31:24];
            endcase
         end
         default:  bus.cpu_din = 8'h00;
      endcase
   end

endmodule

// File: tb/tb_mem_io_bridge.sv
module tb_mem_io_bridge;

   localparam int TX_AW = 4;

   logic             clk_in;
   logic             rst_in;
   logic [TX_AW:0]   dbg_tx_count;
   logic [31:0]      dbg_cycle_cnt;
   logic [1:0]       dbg_sel;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [7:0] exp_q[$];
   logic [7:0] ram_mem [256];
   logic [7:0] exp_byte;

   mem_io_bridge_if bus ();

   mem_io_bridge #(.TX_AW(TX_AW)) dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .bus             (bus),
      .dbg_tx_count_o  (dbg_tx_count),
      .dbg_cycle_cnt_o (dbg_cycle_cnt),
      .dbg_sel_o       (dbg_sel)
   );

   // Clock / watchdog
   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish within time limit");
      $fatal(1);
   end

   // Synchronous RAM model: one-cycle read latency
   always @(posedge clk_in) begin
      if (bus.ram_we) ram_mem[bus.ram_a[7:0]] <= bus.ram_wdata;
      bus.ram_rdata <= ram_mem[bus.ram_a[7:0]];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cpu_set(input logic [31:0] a, input logic wr, input logic [7:0] d);
      bus.cpu_a    = a;
      bus.cpu_wr   = wr;
      bus.cpu_dout = d;
   endtask

   task automatic cpu_idle();
      cpu_set(32'h20000, 1'b0, 8'h00);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) ram_mem[i] = 8'h00;
      bus.ram_rdata = 8'h00;
      rst_in        = 1'b0;
      cpu_idle();
      bus.tx_ready  = 1'b0;
      bus.rx_valid  = 1'b0;
      bus.rx_data   = 8'h00;

      // Reset state
      #1;
      check("rst_cpu_din",   bus.cpu_din, 8'h00);
      check("rst_tx_valid",  bus.tx_valid, 1'b0);
      check("rst_prog_stop", bus.prog_stop, 1'b0);
      check("rst_cycle_cnt", dbg_cycle_cnt, 32'd0);
      check("rst_rx_pop",    bus.rx_pop, 1'b0);
      check("rst_sel",       dbg_sel, 2'd0);
      @(negedge clk_in);
      rst_in = 1'b1;

      // Snapshot starts at zero
      @(negedge clk_in);
      cpu_set(32'h30007, 1'b0, 8'h00);
      @(negedge clk_in);
      cpu_idle();
      #1;
      check("snap_reset_byte3", bus.cpu_din, 8'h00);

      // RAM write then read
      @(negedge clk_in);
      cpu_set(32'h00010, 1'b1, 8'hA5);
      #1;
      check("ram_we_write", bus.ram_we, 1'b1);
      check("ram_a",        bus.ram_a, 17'h00010);
      check("ram_wdata",    bus.ram_wdata, 8'hA5);
      @(negedge clk_in);
      cpu_set(32'h00010, 1'b0, 8'h00);
      #1;
      check("ram_we_read", bus.ram_we, 1'b0);
      @(negedge clk_in);
      cpu_set(32'h20010, 1'b1, 8'h77);
      #1;
      check("ram_rdata_ret", bus.cpu_din, 8'hA5);
      check("unmapped_we",   bus.ram_we, 1'b0);
      @(negedge clk_in);
      cpu_set(32'h20010, 1'b0, 8'h00);
      @(negedge clk_in);
      cpu_idle();
      #1;
      check("unmapped_read", bus.cpu_din, 8'h00);

      // TX ordering and null filtering
      @(negedge clk_in);
      cpu_set(32'h30000, 1'b1, 8'h48); exp_q.push_back(8'h48);
      @(negedge clk_in);
      cpu_set(32'h30000, 1'b1, 8'h00);
      #1;
      check("null_no_stall", bus.cpu_rdy, 1'b1);
      @(negedge clk_in);
      cpu_set(32'h30000, 1'b1, 8'h69); exp_q.push_back(8'h69);
      @(negedge clk_in);
      cpu_idle();
      #1;
      check("tx_count_2", dbg_tx_count, 5'd2);
      bus.tx_ready = 1'b1;
      exp_byte = exp_q.pop_front();
      check("tx_byte0", bus.tx_data, exp_byte);
      @(negedge clk_in);
      #1;
      exp_byte = exp_q.pop_front();
      check("tx_byte1", bus.tx_data, exp_byte);
      check("tx_valid_mid", bus.tx_valid, 1'b1);
      @(negedge clk_in);
      #1;
      check("tx_valid_drained", bus.tx_valid, 1'b0);
      bus.tx_ready = 1'b0;

      // TX full stall
      for (int i = 0; i < 16; i++) begin
         @(negedge clk_in);
         cpu_set(32'h30000, 1'b1, 8'(i + 1));
         exp_q.push_back(8'(i + 1));
         #1;
         check("fill_rdy", bus.cpu_rdy, 1'b1);
      end
      @(negedge clk_in);
      cpu_set(32'h30000, 1'b1, 8'h11);
      #1;
      check("full_stall", bus.cpu_rdy, 1'b0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk_in);
         #1;
         check("full_stall_hold", bus.cpu_rdy, 1'b0);
      end
      check("full_count", dbg_tx_count, 5'd16);
      @(negedge clk_in);
      bus.tx_ready = 1'b1;
      #1;
      check("pop_unstall", bus.cpu_rdy, 1'b1);
      void'(exp_q.pop_front());
      exp_q.push_back(8'h11);
      @(negedge clk_in);
      bus.tx_ready = 1'b0;
      cpu_idle();
      #1;
      check("full_after_swap", dbg_tx_count, 5'd16);
      bus.tx_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         exp_byte = exp_q.pop_front();
         check("drain_byte", bus.tx_data, exp_byte);
         @(negedge clk_in);
         #1;
      end
      check("drain_empty", bus.tx_valid, 1'b0);
      bus.tx_ready = 1'b0;

      // RX stall and pop
      @(negedge clk_in);
      cpu_set(32'h30000, 1'b0, 8'h00);
      #1;
      check("rx_stall", bus.cpu_rdy, 1'b0);
      check("rx_no_pop", bus.rx_pop, 1'b0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk_in);
         #1;
         check("rx_stall_hold", bus.cpu_rdy, 1'b0);
      end
      @(negedge clk_in);
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'h3C;
      #1;
      check("rx_unstall", bus.cpu_rdy, 1'b1);
      check("rx_pop_pulse", bus.rx_pop, 1'b1);
      @(negedge clk_in);
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      cpu_idle();
      #1;
      check("rx_pop_single", bus.rx_pop, 1'b0);
      check("rx_data_ret", bus.cpu_din, 8'h3C);

      // Cycle counter snapshot
      @(negedge clk_in);
      rst_in = 1'b0;
      #1;
      check("cnt_reset", dbg_cycle_cnt, 32'd0);
      @(negedge clk_in);
      rst_in = 1'b1;
      repeat (32'h123) @(posedge clk_in);
      @(negedge clk_in);
      check("cnt_value", dbg_cycle_cnt, 32'h123);
      cpu_set(32'h30004, 1'b0, 8'h00);
      @(negedge clk_in);
      #1;
      check("snap_byte0", bus.cpu_din, 8'h23);
      cpu_set(32'h30005, 1'b0, 8'h00);
      @(negedge clk_in);
      #1;
      check("snap_byte1", bus.cpu_din, 8'h01);
      cpu_idle();
      repeat (5) @(negedge clk_in);
      cpu_set(32'h30005, 1'b0, 8'h00);
      @(negedge clk_in);
      #1;
      check("snap_held", bus.cpu_din, 8'h01);
      cpu_set(32'h30006, 1'b0, 8'h00);
      @(negedge clk_in);
      #1;
      check("snap_byte2", bus.cpu_din, 8'h00);
      cpu_idle();

      // Program stop and asynchronous reset
      @(negedge clk_in);
      cpu_set(32'h30004, 1'b1, 8'h55);
      #1;
      check("stop_rdy", bus.cpu_rdy, 1'b1);
      @(negedge clk_in);
      cpu_idle();
      #1;
      check("prog_stop_set", bus.prog_stop, 1'b1);
      check("stop_queued",   bus.tx_valid, 1'b1);
      check("stop_byte",     bus.tx_data, 8'h00);
      check("stop_count",    dbg_tx_count, 5'd1);
      @(posedge clk_in);
      #2;
      rst_in = 1'b0;
      #1;
      check("async_prog_stop", bus.prog_stop, 1'b0);
      check("async_tx_valid",  bus.tx_valid, 1'b0);
      check("async_cycle_cnt", dbg_cycle_cnt, 32'd0);
      @(negedge clk_in);
      rst_in = 1'b1;
      @(negedge clk_in);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
